// File: rtl/color_bounce_render_if.sv
// Control and VGA plot-bus signals between the frame controller, the renderer and vga_adapter.
// The master side requests a render; the slave side is the renderer that drives the pixel bus.
interface color_bounce_render_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output start, input busy, done, x, y, colour, plot);
  modport slave  (input start, output busy, done, x, y, colour, plot);
endinterface

// File: rtl/color_bounce_render.sv
// Snapshots ball/platform state on start and rasterises erase-ball, ball and four platforms
// into the VGA plot interface, one pixel per cycle, with every output registered.
module color_bounce_render #(
  parameter logic [7:0] BALL_X       = 8'd40,
  parameter int         BALL_SIZE    = 4,
  parameter int         PLAT_W       = 16,
  parameter int         PLAT_H       = 2,
  parameter logic [6:0] PLAT_Y0      = 7'd30,
  parameter logic [6:0] PLAT_SPACING = 7'd24,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            prev_ball_in,
  input  logic [7:0]            curr_ball_in,
  input  logic [2:0]            color_ball_in,
  input  logic [11:0]           color_plats_in,
  input  logic [27:0]           position_plats_in,
  color_bounce_render_if.slave  bus
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_ERASE | painting previous ball square with background
  // S_BALL  | painting current ball square
  // S_PLAT  | painting platform r_idx
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_BALL, S_PLAT, S_DONE} state_t;

  localparam logic [4:0] BALL_LAST = 5'(BALL_SIZE - 1);
  localparam logic [4:0] PW_LAST   = 5'(PLAT_W - 1);
  localparam logic [4:0] PH_LAST   = 5'(PLAT_H - 1);

  state_t      r_state, w_state_n;
  logic [4:0]  r_dx, r_dy, w_dx_n, w_dy_n;
  logic [1:0]  r_idx, w_idx_n;
  logic [7:0]  r_prev, r_curr, w_prev_n, w_curr_n;
  logic [2:0]  r_cball, w_cball_n;
  logic [11:0] r_cplats, w_cplats_n;
  logic [27:0] r_pos, w_pos_n;
  logic [7:0]  r_x, w_x_n;
  logic [6:0]  r_y;
  logic [2:0]  r_colour, w_colour_n;
  logic        r_plot, r_busy, r_done, w_busy_n;
  logic [7:0]  w_yb;
  logic [6:0]  w_plat_y;

  always_comb begin
    w_state_n  = r_state;
    w_dx_n     = r_dx;
    w_dy_n     = r_dy;
    w_idx_n    = r_idx;
    w_prev_n   = r_prev;
    w_curr_n   = r_curr;
    w_cball_n  = r_cball;
    w_cplats_n = r_cplats;
    w_pos_n    = r_pos;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_prev_n   = prev_ball_in;
          w_curr_n   = curr_ball_in;
          w_cball_n  = color_ball_in;
          w_cplats_n = color_plats_in;
          w_pos_n    = position_plats_in;
          w_dx_n     = '0;
          w_dy_n     = '0;
          w_idx_n    = '0;
          w_state_n  = (prev_ball_in == curr_ball_in) ? S_BALL : S_ERASE;
        end
      end
      S_ERASE, S_BALL: begin
        if (r_dx != BALL_LAST) begin
          w_dx_n = r_dx + 5'd1;
        end else begin
          w_dx_n = '0;
          if (r_dy != BALL_LAST) begin
            w_dy_n = r_dy + 5'd1;
          end else begin
            w_dy_n    = '0;
            w_idx_n   = '0;
            w_state_n = (r_state == S_ERASE) ? S_BALL : S_PLAT;
          end
        end
      end
      S_PLAT: begin
        if (r_dx != PW_LAST) begin
          w_dx_n = r_dx + 5'd1;
        end else begin
          w_dx_n = '0;
          if (r_dy != PH_LAST) begin
            w_dy_n = r_dy + 5'd1;
          end else begin
            w_dy_n = '0;
            if (r_idx == 2'd3) w_state_n = S_DONE;
            else               w_idx_n   = r_idx + 2'd1;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Outputs are derived from the next pixel so the registered bus shows it one cycle after start.
  always_comb begin
    w_x_n      = '0;
    w_yb       = '0;
    w_colour_n = '0;
    w_busy_n   = 1'b0;
    w_plat_y   = PLAT_Y0 + 7'(w_idx_n) * PLAT_SPACING + 7'(w_dy_n);
    case (w_state_n)
      S_ERASE: begin
        w_x_n      = BALL_X + {3'b000, w_dx_n};
        w_yb       = w_prev_n + {3'b000, w_dy_n};
        w_colour_n = BG_COLOUR;
        w_busy_n   = 1'b1;
      end
      S_BALL: begin
        w_x_n      = BALL_X + {3'b000, w_dx_n};
        w_yb       = w_curr_n + {3'b000, w_dy_n};
        w_colour_n = w_cball_n;
        w_busy_n   = 1'b1;
      end
      S_PLAT: begin
        w_x_n      = {1'b0, w_pos_n[int'(w_idx_n) * 7 +: 7]} + {3'b000, w_dx_n};
        w_yb       = {1'b0, w_plat_y};
        w_colour_n = w_cplats_n[int'(w_idx_n) * 3 +: 3];
        w_busy_n   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dx     <= '0;
      r_dy     <= '0;
      r_idx    <= '0;
      r_prev   <= '0;
      r_curr   <= '0;
      r_cball  <= '0;
      r_cplats <= '0;
      r_pos    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_dx     <= w_dx_n;
      r_dy     <= w_dy_n;
      r_idx    <= w_idx_n;
      r_prev   <= w_prev_n;
      r_curr   <= w_curr_n;
      r_cball  <= w_cball_n;
      r_cplats <= w_cplats_n;
      r_pos    <= w_pos_n;
      r_x      <= w_x_n;
      r_y      <= w_yb[6:0];
      r_colour <= w_colour_n;
      r_plot   <= w_busy_n && (w_yb < 8'd120);
      r_busy   <= w_busy_n;
      r_done   <= (w_state_n == S_DONE);
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_color_bounce_render.sv
// Scoreboard bench for color_bounce_render: a reference rasteriser queues every expected
// bus cycle when a frame is requested, and each DUT cycle pops and compares one entry.
module tb_color_bounce_render;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  prev_ball_in, curr_ball_in;
  logic [2:0]  color_ball_in;
  logic [11:0] color_plats_in;
  logic [27:0] position_plats_in;

  color_bounce_render_if bus ();

  color_bounce_render dut (
    .clk               (clk),
    .reset             (reset),
    .prev_ball_in      (prev_ball_in),
    .curr_ball_in      (curr_ball_in),
    .color_ball_in     (color_ball_in),
    .color_plats_in    (color_plats_in),
    .position_plats_in (position_plats_in),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       plot;
    logic [2:0] colour;
    logic [6:0] y;
    logic [7:0] x;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_rect(input logic [7:0] x0, input logic [7:0] y0, input int w, input int h,
                           input logic [2:0] c);
    pix_t p;
    logic [7:0] yy;
    for (int dy = 0; dy < h; dy++) begin
      for (int dx = 0; dx < w; dx++) begin
        yy       = y0 + 8'(dy);
        p.x      = x0 + 8'(dx);
        p.y      = yy[6:0];
        p.colour = c;
        p.plot   = (yy < 8'd120);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] prev, input logic [7:0] curr, input logic [2:0] cb,
                             input logic [11:0] cp, input logic [27:0] pos);
    if (prev != curr) push_rect(8'd40, prev, 4, 4, 3'b000);
    push_rect(8'd40, curr, 4, 4, cb);
    for (int i = 0; i < 4; i++)
      push_rect({1'b0, pos[7*i +: 7]}, 8'(30 + 24*i), 16, 2, cp[3*i +: 3]);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic render(input logic [7:0] prev, input logic [7:0] curr, input logic [2:0] cb,
                        input logic [11:0] cp, input logic [27:0] pos,
                        input int disturb_at, input int reset_at);
    pix_t p;
    int   k;
    int   dones;
    prev_ball_in      = prev;
    curr_ball_in      = curr;
    color_ball_in     = cb;
    color_plats_in    = cp;
    position_plats_in = pos;
    model_frame(prev, curr, cb, cp, pos);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      check($sformatf("pix%0d", k), {bus.busy, bus.done, bus.plot, bus.colour, bus.y, bus.x},
            {1'b1, 1'b0, p});
      k++;
      if (k == disturb_at) begin
        bus.start         = 1'b1;
        prev_ball_in      = 8'd5;
        curr_ball_in      = 8'd77;
        color_ball_in     = 3'b111;
        color_plats_in    = ~cp;
        position_plats_in = ~pos;
      end
      if (k == reset_at) begin
        reset = 1'b1;
        exp_q.delete();
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (reset_at > 0) begin
      check("abort_outputs", {bus.busy, bus.done, bus.plot, bus.colour, bus.y, bus.x}, 32'd0);
      reset = 1'b0;
      dones = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (bus.done) dones++;
      end
      check("abort_no_done", dones, 0);
    end else begin
      check("done_pulse", {bus.busy, bus.done, bus.plot}, 3'b010);
      @(negedge clk);
      check("done_once", {bus.busy, bus.done, bus.plot}, 3'b000);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.start         = 1'b0;
    prev_ball_in      = '0;
    curr_ball_in      = '0;
    color_ball_in     = '0;
    color_plats_in    = '0;
    position_plats_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.plot, bus.colour, bus.y, bus.x}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // erase + draw, one platform coloured 000
    render(8'd50, 8'd54, 3'b100, 12'o0246, {7'd3, 7'd40, 7'd80, 7'd120}, 0, 0);
    // no erase, started back-to-back in the IDLE cycle after done
    render(8'd20, 8'd20, 3'b011, 12'o1234, {7'd9, 7'd19, 7'd29, 7'd39}, 0, 0);
    // platform x/colour extremes
    render(8'd60, 8'd61, 3'b010, 12'o7531, {7'd0, 7'd10, 7'd100, 7'd127}, 0, 0);
    // ball clipping below row 120
    render(8'd110, 8'd118, 3'b101, 12'o4444, {7'd1, 7'd2, 7'd3, 7'd4}, 0, 0);
    // 8-bit wrap of erase rows and clipped previous ball
    render(8'd254, 8'd118, 3'b110, 12'o1111, {7'd50, 7'd60, 7'd70, 7'd80}, 0, 0);
    // re-start with changed inputs mid-render must be ignored
    render(8'd30, 8'd34, 3'b001, 12'o3210, {7'd11, 7'd22, 7'd33, 7'd44}, 10, 0);
    // reset at pixel 30 aborts, then a normal render
    render(8'd70, 8'd74, 3'b111, 12'o5555, {7'd5, 7'd6, 7'd7, 7'd8}, 0, 30);
    render(8'd70, 8'd74, 3'b111, 12'o5555, {7'd5, 7'd6, 7'd7, 7'd8}, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
